alu_exec_unit: RTL



---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_comb_core.sv | 45 ++++
 rtl/alu_exec_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the execute-stage ALU: op-code values
//            (identical to those emitted by the ALU control decoder), the
//            execute FSM state encoding and the default datapath width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_XOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Shift ops go through the serial shifter; everything else is one cycle.
  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_comb_core
// Purpose  : Single-cycle combinational part of the ALU: AND, OR, XOR, ADD,
//            SUB, SLT (signed) and SLTU (unsigned). Shift codes and unknown
//            codes produce 0; shifts are handled by the serial shifter.
// Ports    : alu_ctrl_i - operation code
//            op_a_i     - operand A
//            op_b_i     - operand B
//            result_o   - combinational result
// Revision : 1.0 - initial release
// ============================================================================
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] result_o
);

  logic w_lt_signed;
  logic w_lt_unsigned;

  assign w_lt_signed   = $signed(op_a_i) < $signed(op_b_i);
  assign w_lt_unsigned = op_a_i < op_b_i;

  always_comb begin
    result_o = '0;
    case (alu_ctrl_i)
      ALU_AND:  result_o = op_a_i & op_b_i;
      ALU_OR:   result_o = op_a_i | op_b_i;
      ALU_XOR:  result_o = op_a_i ^ op_b_i;
      ALU_ADD:  result_o = op_a_i + op_b_i;
      ALU_SUB:  result_o = op_a_i - op_b_i;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, w_lt_signed};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
      default:  result_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU with valid/ready handshake on both sides.
//            Logic/arith/compare ops finish in one cycle; shifts run through
//            a one-bit-per-cycle serial shifter. flush aborts any in-flight
//            or held operation.
// Ports    : clk, rst_n          - clock, async active-low reset
//            flush               - synchronous abort (branch redirect)
//            in_valid / in_ready - upstream handshake
//            alu_ctrl, op_a, op_b- operation and operands (sampled at accept)
//            out_valid/out_ready - downstream handshake
//            result, zero        - registered result and (result == 0)
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [3:0]         sh_ctrl_q;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   comb_result;

  alu_comb_core #(
    .WIDTH (WIDTH)
  ) u_comb_core (
    .alu_ctrl_i (alu_ctrl),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .result_o   (comb_result)
  );

  // A held result may be replaced in the same cycle it is consumed.
  assign in_ready = !flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SHAMT_W-1:0];

  // One-bit step of the serial shifter for the captured shift op.
  always_comb begin
    work_d = work_q;
    case (sh_ctrl_q)
      ALU_SLL: work_d = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRL: work_d = {1'b0, work_q[WIDTH-1:1]};
      ALU_SRA: work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: work_d = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      sh_ctrl_q   <= ALU_AND;
    end else if (flush) begin
      // result_q deliberately keeps its last value.
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_shift_op(alu_ctrl) && (shamt != '0)) begin
              work_q      <= op_a;
              cnt_q       <= shamt;
              sh_ctrl_q   <= alu_ctrl;
              state_q     <= ST_SHIFT;
              out_valid_q <= 1'b0;
            end else begin
              // Zero-distance shift degenerates to a pass-through of op_a.
              result_q    <= is_shift_op(alu_ctrl) ? op_a : comb_result;
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            result_q    <= work_d;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = (result_q == '0);

endmodule
`default_nettype wire
